tx_frame_scheduler: RTL and testbench

TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

---
 rtl/tx_frame_scheduler.sv | 139 +++++++++++++
 tb/tb_tx_frame_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_scheduler.sv
// Drains a byte buffer into SYNC / LEN / payload / CKSUM frames for a UART transmitter.
// Full frames leave as soon as enough bytes are buffered; partial buffers flush after an idle timeout.
module tx_frame_scheduler #(
    parameter int         MAX_PAYLOAD  = 32,
    parameter int         IDLE_TIMEOUT = 50000,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [9:0]  buf_count,
    input  logic        buf_empty,
    output logic        buf_rd_en,
    input  logic [7:0]  buf_rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] frames_sent
);
    localparam int            TW        = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(IDLE_TIMEOUT - 1);
    localparam logic [9:0]    MAX_COUNT = 10'(MAX_PAYLOAD);

    typedef enum logic [2:0] {IDLE, SYNC, LEN, RD_REQ, RD_WAIT, PAYLOAD, CKSUM} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_len;
    logic [7:0]    r_remaining;
    logic [7:0]    r_payload;
    logic [7:0]    r_sum;
    logic [15:0]   r_frames_sent;
    logic [TW-1:0] r_timer;
    logic          w_full;
    logic          w_partial;
    logic          w_start;
    logic          w_xfer;
    logic [7:0]    w_len;

    assign w_full    = (buf_count >= MAX_COUNT);
    assign w_partial = (buf_count != 10'd0) && !w_full;
    assign w_start   = enable && (w_full || (w_partial && (r_timer == TIMER_MAX)));
    assign w_len     = w_full ? MAX_COUNT[7:0] : buf_count[7:0];
    assign w_xfer    = tx_valid && tx_ready;

    assign busy        = (r_state != IDLE);
    assign frames_sent = r_frames_sent;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_len         <= 8'd0;
            r_remaining   <= 8'd0;
            r_payload     <= 8'd0;
            r_sum         <= 8'd0;
            r_timer       <= '0;
            r_frames_sent <= 16'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    // LEN is frozen here so later buffer growth cannot alter the frame in flight
                    if (w_start) begin
                        r_len       <= w_len;
                        r_remaining <= w_len;
                        r_sum       <= 8'd0;
                        r_timer     <= '0;
                    end else if (!w_partial) begin
                        r_timer <= '0;
                    end else if (r_timer != TIMER_MAX) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                LEN: begin
                    if (w_xfer) r_sum <= r_sum + r_len;
                end
                RD_WAIT: begin
                    r_payload <= buf_rd_data;
                end
                PAYLOAD: begin
                    if (w_xfer) begin
                        r_sum       <= r_sum + r_payload;
                        r_remaining <= r_remaining - 8'd1;
                    end
                end
                CKSUM: begin
                    if (w_xfer) r_frames_sent <= r_frames_sent + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // One buffer read per payload byte; tx_valid and buf_rd_en live in disjoint states
    always_comb begin
        w_next    = r_state;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        buf_rd_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) w_next = SYNC;
            end
            SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) w_next = LEN;
            end
            LEN: begin
                tx_valid = 1'b1;
                tx_data  = r_len;
                if (tx_ready) w_next = RD_REQ;
            end
            RD_REQ: begin
                if (!buf_empty) begin
                    buf_rd_en = 1'b1;
                    w_next    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                w_next = PAYLOAD;
            end
            PAYLOAD: begin
                tx_valid = 1'b1;
                tx_data  = r_payload;
                if (tx_ready) w_next = (r_remaining == 8'd1) ? CKSUM : RD_REQ;
            end
            CKSUM: begin
                tx_valid = 1'b1;
                tx_data  = ~r_sum + 8'd1;
                if (tx_ready) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Self-checking bench for tx_frame_scheduler: table of full frames plus directed
// sequences for timeout flush, enable gating, mid-frame reset and back-to-back frames.
module tb_tx_frame_scheduler;
    localparam int MAX_PAYLOAD  = 4;
    localparam int IDLE_TIMEOUT = 100;

    typedef struct {
        logic [31:0] payload;
        int          stallCycles;
        logic [55:0] expStream;
        logic [15:0] expFrames;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        txReady = 1'b1;
    logic [9:0]  bufCount;
    logic        bufEmpty;
    logic        bufRdEn;
    logic [7:0]  bufRdData = 8'h00;
    logic [7:0]  txData;
    logic        txValid;
    logic        busy;
    logic [15:0] framesSent;

    logic [7:0]  mem [0:1023];
    logic [7:0]  capMem [0:1023];
    int          wrPtr = 0;
    int          rdPtr = 0;
    int          capCnt = 0;
    int          capRd = 0;
    int          rdPulses = 0;
    int          protocolErrors = 0;
    logic        popReq = 1'b0;
    logic        prevValid = 1'b0;
    logic        prevReady = 1'b0;
    logic [7:0]  prevData = 8'h00;
    int          checks = 0;
    int          failures = 0;

    assign bufCount = 10'(wrPtr - rdPtr);
    assign bufEmpty = (wrPtr == rdPtr);

    tx_frame_scheduler #(
        .MAX_PAYLOAD (MAX_PAYLOAD),
        .IDLE_TIMEOUT(IDLE_TIMEOUT),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .buf_count  (bufCount),
        .buf_empty  (bufEmpty),
        .buf_rd_en  (bufRdEn),
        .buf_rd_data(bufRdData),
        .tx_data    (txData),
        .tx_valid   (txValid),
        .tx_ready   (txReady),
        .busy       (busy),
        .frames_sent(framesSent)
    );

    always #5 clk = ~clk;

    // Buffer model: read data appears the cycle after the read pulse; reset empties it
    always @(posedge clk) begin
        if (rst) begin
            rdPtr <= wrPtr;
        end else if (popReq) begin
            bufRdData <= mem[rdPtr[9:0]];
            rdPtr     <= rdPtr + 1;
        end
    end

    always @(negedge clk) begin
        prevValid <= txValid && !rst;
        prevReady <= txReady;
        prevData  <= txData;
        popReq    <= bufRdEn && !rst;
        if (!rst) begin
            if (bufRdEn) rdPulses <= rdPulses + 1;
            if (txValid && txReady) begin
                capMem[capCnt[9:0]] <= txData;
                capCnt <= capCnt + 1;
            end
            if ((bufRdEn && txValid) ||
                (prevValid && !prevReady && (!txValid || (txData != prevData))))
                protocolErrors <= protocolErrors + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        mem[wrPtr[9:0]] = b;
        wrPtr = wrPtr + 1;
    endtask

    task automatic collectBytes(input int nBytes, input int stall, input int budget, input string name);
        int target;
        int waitCnt;
        int cycles;
        target  = capCnt + nBytes;
        waitCnt = 0;
        cycles  = 0;
        while ((capCnt < target) && (cycles < budget)) begin
            @(posedge clk);
            #1;
            cycles = cycles + 1;
            if (stall == 0) begin
                txReady = 1'b1;
            end else if (txValid && (waitCnt < stall)) begin
                txReady = 1'b0;
                waitCnt = waitCnt + 1;
            end else if (txValid) begin
                txReady = 1'b1;
                waitCnt = 0;
            end else begin
                txReady = 1'b0;
            end
        end
        checkOutput(name, 32'(capCnt >= target), 32'd1);
        txReady = 1'b1;
    endtask

    task automatic expectBytes(input string name, input logic [55:0] stream, input int n);
        logic [7:0]  expByte;
        logic [31:0] actual;
        for (int i = 0; i < n; i++) begin
            expByte = stream[55-8*i -: 8];
            if (capRd < capCnt) actual = {24'h0, capMem[capRd[9:0]]};
            else                actual = 32'hFFFF_FFFF;
            checkOutput($sformatf("%s byte%0d", name, i), actual, {24'h0, expByte});
            capRd = capRd + 1;
        end
    endtask

    task automatic waitValid(input int budget, output int cycles, output logic sawBusy);
        cycles  = 0;
        sawBusy = 1'b0;
        do begin
            @(posedge clk);
            #1;
            cycles = cycles + 1;
            if (busy && !txValid) sawBusy = 1'b1;
        end while (!txValid && (cycles < budget));
    endtask

    initial begin
        vec_t vecs [4];
        int   cycles;
        int   rdBefore;
        logic sawBusy;
        logic bad;

        vecs[0] = '{payload: 32'h01020304, stallCycles: 0,  expStream: 56'hA5_04_01_02_03_04_F2, expFrames: 16'd1};
        vecs[1] = '{payload: 32'h01020304, stallCycles: 50, expStream: 56'hA5_04_01_02_03_04_F2, expFrames: 16'd2};
        vecs[2] = '{payload: 32'hFFFFFFFF, stallCycles: 0,  expStream: 56'hA5_04_FF_FF_FF_FF_00, expFrames: 16'd3};
        vecs[3] = '{payload: 32'h807F0011, stallCycles: 3,  expStream: 56'hA5_04_80_7F_00_11_EC, expFrames: 16'd4};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset tx_valid", 32'(txValid), 32'd0);
        checkOutput("reset tx_data", 32'(txData), 32'd0);
        checkOutput("reset buf_rd_en", 32'(bufRdEn), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset frames_sent", 32'(framesSent), 32'd0);
        rst    = 1'b0;
        enable = 1'b1;

        for (int v = 0; v < 4; v++) begin
            rdBefore = rdPulses;
            for (int b = 0; b < 4; b++) applyStimulus(vecs[v].payload[31-8*b -: 8]);
            collectBytes(7, vecs[v].stallCycles, 2000, $sformatf("vec%0d collect", v));
            expectBytes($sformatf("vec%0d", v), vecs[v].expStream, 7);
            repeat (2) @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d frames_sent", v), 32'(framesSent), 32'(vecs[v].expFrames));
            checkOutput($sformatf("vec%0d rd pulses", v), 32'(rdPulses - rdBefore), 32'd4);
        end

        // Partial buffer flushes only after the idle timer saturates
        applyStimulus(8'h10);
        applyStimulus(8'h20);
        waitValid(300, cycles, sawBusy);
        checkOutput("timeout latency", 32'(cycles), 32'd100);
        checkOutput("timeout quiet", 32'(sawBusy), 32'd0);
        collectBytes(5, 0, 100, "timeout collect");
        expectBytes("timeout", 56'hA5_02_10_20_CE_00_00, 5);

        // enable dropped after LEN: frame finishes, nothing new until enable returns
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
        applyStimulus(8'h05); applyStimulus(8'h06); applyStimulus(8'h07); applyStimulus(8'h08);
        collectBytes(2, 0, 50, "endrop header");
        enable = 1'b0;
        collectBytes(5, 0, 100, "endrop rest");
        expectBytes("endrop frame", 56'hA5_04_11_22_33_44_52, 7);
        bad = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (busy || txValid) bad = 1'b1;
        end
        checkOutput("endrop stays idle", 32'(bad), 32'd0);
        checkOutput("endrop frames_sent", 32'(framesSent), 32'd6);
        enable = 1'b1;
        waitValid(10, cycles, sawBusy);
        checkOutput("endrop restart latency", 32'(cycles), 32'd1);
        collectBytes(7, 0, 100, "endrop next collect");
        expectBytes("endrop next", 56'hA5_04_05_06_07_08_E2, 7);

        // Timer keeps saturating while disabled; flush starts as soon as enable rises
        enable = 1'b0;
        applyStimulus(8'h3C);
        bad = 1'b0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (busy) bad = 1'b1;
        end
        checkOutput("disabled no flush", 32'(bad), 32'd0);
        enable = 1'b1;
        waitValid(10, cycles, sawBusy);
        checkOutput("enable rise flush latency", 32'(cycles), 32'd1);
        collectBytes(4, 0, 100, "enable rise collect");
        expectBytes("enable rise", 56'hA5_01_3C_C3_00_00_00, 4);

        // Reset in PAYLOAD aborts the frame and clears the counter
        applyStimulus(8'hAA); applyStimulus(8'hBB); applyStimulus(8'hCC); applyStimulus(8'hDD);
        collectBytes(3, 0, 50, "rst head collect");
        expectBytes("rst head", 56'hA5_04_AA_00_00_00_00, 3);
        txReady = 1'b0;
        waitValid(10, cycles, sawBusy);
        checkOutput("rst payload held", 32'(txData), 32'hBB);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst tx_valid", 32'(txValid), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst frames_sent", 32'(framesSent), 32'd0);
        rst     = 1'b0;
        txReady = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h04);
        collectBytes(7, 0, 100, "post rst collect");
        expectBytes("post rst", 56'hA5_04_01_02_03_04_F2, 7);

        // Nine bytes: two full frames back-to-back, then a single-byte flush
        for (int b = 1; b <= 9; b++) applyStimulus(8'(b));
        collectBytes(14, 0, 40, "nine collect");
        expectBytes("nine frame1", 56'hA5_04_01_02_03_04_F2, 7);
        expectBytes("nine frame2", 56'hA5_04_05_06_07_08_E2, 7);
        waitValid(300, cycles, sawBusy);
        checkOutput("nine tail latency", 32'(cycles), 32'd100);
        collectBytes(4, 0, 100, "nine tail collect");
        expectBytes("nine tail", 56'hA5_01_09_F6_00_00_00, 4);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("nine frames_sent", 32'(framesSent), 32'd4);
        checkOutput("protocol errors", 32'(protocolErrors), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
